// File: rtl/fifo_rd_stream_pkg.sv
// Shared constants and elaboration helpers for the fifo read-stream adapter.
package fifo_rd_stream_pkg;

  localparam int STATS_CNT_W = 32;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/fifo_rd_stream_buf.sv
// Circular skid storage for fifo_rd_stream: explicit-wrap pointers (any depth >= 2)
// and an occupancy count that stays put on a simultaneous write and read.
module fifo_rd_stream_buf
  import fifo_rd_stream_pkg::*;
#(
  parameter int data_word_size_g = 8,
  parameter int buf_depth_g      = 3,
  localparam int PTR_W = (clog2(buf_depth_g) < 1) ? 1 : clog2(buf_depth_g),
  localparam int CNT_W = clog2(buf_depth_g + 1)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        wr_en_i,
  input  logic [data_word_size_g-1:0] wr_data_i,
  input  logic                        rd_en_i,
  output logic [data_word_size_g-1:0] rd_data_o,
  output logic [CNT_W-1:0]            count_o
);

  logic [data_word_size_g-1:0] mem_q [buf_depth_g];
  logic [PTR_W-1:0]            wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]            count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(buf_depth_g - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    count_d = count_q;
    if (wr_en_i && !rd_en_i) begin
      count_d = count_q + CNT_W'(1);
    end else if (!wr_en_i && rd_en_i) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < buf_depth_g; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en_i) begin
        mem_q[wr_ptr_q] <= wr_data_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (rd_en_i) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      count_q <= count_d;
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  // The pop credit rule should make a write into a full buffer unreachable.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_i)
    wr_en_i |-> (count_q != CNT_W'(buf_depth_g)));

endmodule

// File: rtl/fifo_rd_stream.sv
// Fifo pop interface -> valid/ready stream adapter with credit-based prefetch.
// Optional FIFO_RD_STREAM_STATS_EN adds transfer and stall counters.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int data_word_size_g = 8,
  parameter int buf_depth_g      = 3
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        clk_en_i,
  input  logic                        fifo_empty_i,
  input  logic [data_word_size_g-1:0] fifo_data_i,
  output logic                        fifo_r_en_o,
  output logic [data_word_size_g-1:0] m_data_o,
  output logic                        m_valid_o,
  input  logic                        m_ready_i
`ifdef FIFO_RD_STREAM_STATS_EN
  ,
  output logic [STATS_CNT_W-1:0]      xfer_count_o,
  output logic [STATS_CNT_W-1:0]      stall_count_o
`endif
);

  localparam int CNT_W = clog2(buf_depth_g + 1);

  logic             inflight_q, inflight_d;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   credit_used;
  logic             pop, capture, xfer;

  // Credits cover both stored and in-flight words, so m_ready_i never reaches the pop.
  assign credit_used = {1'b0, count} + (CNT_W + 1)'(inflight_q);
  assign pop         = rst_i & clk_en_i & ~fifo_empty_i
                       & (credit_used < (CNT_W + 1)'(buf_depth_g));
  assign capture     = clk_en_i & inflight_q;
  assign m_valid_o   = (count != '0);
  assign xfer        = clk_en_i & m_valid_o & m_ready_i;
  assign fifo_r_en_o = pop;

  always_comb begin
    inflight_d = inflight_q;
    if (clk_en_i) begin
      inflight_d = pop;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  fifo_rd_stream_buf #(
    .data_word_size_g(data_word_size_g),
    .buf_depth_g     (buf_depth_g)
  ) u_buf (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .wr_en_i  (capture),
    .wr_data_i(fifo_data_i),
    .rd_en_i  (xfer),
    .rd_data_o(m_data_o),
    .count_o  (count)
  );

`ifdef FIFO_RD_STREAM_STATS_EN
  logic [STATS_CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;
  logic [STATS_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    xfer_cnt_d  = xfer_cnt_q + STATS_CNT_W'(xfer);
    stall_cnt_d = stall_cnt_q + STATS_CNT_W'(clk_en_i & m_valid_o & ~m_ready_i);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      xfer_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      xfer_cnt_q  <= xfer_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign xfer_count_o  = xfer_cnt_q;
  assign stall_count_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a behavioural pop-interface fifo model.
module tb_fifo_rd_stream;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       clk_en_i;
  logic       fifo_empty_i;
  logic [7:0] fifo_data_i = 8'h00;
  logic       fifo_r_en_o;
  logic [7:0] m_data_o;
  logic       m_valid_o;
  logic       m_ready_i;
`ifdef FIFO_RD_STREAM_STATS_EN
  logic [31:0] xfer_count_o, stall_count_o;
`endif

  int checks = 0;
  int errors = 0;

  fifo_rd_stream #(.data_word_size_g(8), .buf_depth_g(3)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clk_en_i     (clk_en_i),
    .fifo_empty_i (fifo_empty_i),
    .fifo_data_i  (fifo_data_i),
    .fifo_r_en_o  (fifo_r_en_o),
    .m_data_o     (m_data_o),
    .m_valid_o    (m_valid_o),
    .m_ready_i    (m_ready_i)
`ifdef FIFO_RD_STREAM_STATS_EN
    ,
    .xfer_count_o (xfer_count_o),
    .stall_count_o(stall_count_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Fifo model: head advances on pop edges, tail is filled by the stimulus.
  logic [7:0] fmem [2048];
  int head = 0;
  int tail = 0;
  assign fifo_empty_i = (head == tail);

  always @(posedge clk_i) begin
    if (fifo_r_en_o) begin
      fifo_data_i <= fmem[head];
      head        <= head + 1;
    end
  end

  typedef struct packed {
    logic       en;
    logic       rdy;
    logic       exp_ren;
    logic       exp_v;
    logic [7:0] exp_d;
  } vec_t;

  vec_t tbl2 [6];
  vec_t tbl3 [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] w);
    fmem[tail] = w;
    tail = tail + 1;
  endtask

  function automatic logic [7:0] word(input int i);
    return 8'(i * 37 + 5);
  endfunction

  task automatic run_vec(input vec_t v, input string nm);
    clk_en_i  = v.en;
    m_ready_i = v.rdy;
    #1;
    chk({nm, "_ren"}, 32'(fifo_r_en_o), 32'(v.exp_ren));
    chk({nm, "_valid"}, 32'(m_valid_o), 32'(v.exp_v));
    if (v.exp_v) chk({nm, "_data"}, 32'(m_data_o), 32'(v.exp_d));
    @(negedge clk_i);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int pushed, recv;
    bit prev_stall;
    logic [7:0] prev_d;

    tbl2[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl2[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl2[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h11};
    tbl2[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h22};
    tbl2[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h33};
    tbl2[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00};

    tbl3[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl3[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl3[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl3[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h11};
    tbl3[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h11};
    tbl3[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h11};
    tbl3[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h11};
    tbl3[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h11};
    tbl3[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h22};
    tbl3[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h33};
    tbl3[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h44};
    tbl3[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h55};
    tbl3[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00};

    // Reset and idle with an empty fifo
    rst_i = 1'b0; clk_en_i = 1'b0; m_ready_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    clk_en_i = 1'b1;
    #1;
    chk("rst_valid", 32'(m_valid_o), 32'd0);
    chk("rst_data", 32'(m_data_o), 32'd0);
    chk("rst_ren", 32'(fifo_r_en_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    for (int i = 0; i < 5; i++) run_vec('{1'b1, 1'b1, 1'b0, 1'b0, 8'h00}, "idle");

    // Three words, consumer always ready: no bubbles
    push(8'h11); push(8'h22); push(8'h33);
    for (int i = 0; i < 6; i++) run_vec(tbl2[i], $sformatf("t2_row%0d", i));

    // Five words, consumer stalled, clock-enable gaps, empty rising with a word in flight
    push(8'h11); push(8'h22); push(8'h33); push(8'h44); push(8'h55);
    for (int i = 0; i < 13; i++) run_vec(tbl3[i], $sformatf("t3_row%0d", i));

    // Random ready and clock enable over 1000 words
    pushed = 0; recv = 0; prev_stall = 1'b0; prev_d = 8'h00;
    for (int cyc = 0; cyc < 30000 && recv < 1000; cyc++) begin
      if (pushed < 1000 && $urandom_range(0, 3) != 0) begin
        push(word(pushed));
        pushed++;
      end
      clk_en_i  = ($urandom_range(0, 3) != 0);
      m_ready_i = 1'($urandom_range(0, 1));
      #1;
      if (prev_stall) begin
        chk("t4_hold_valid", 32'(m_valid_o), 32'd1);
        chk("t4_hold_data", 32'(m_data_o), 32'(prev_d));
      end
      if (clk_en_i && m_valid_o && m_ready_i) begin
        chk($sformatf("t4_order%0d", recv), 32'(m_data_o), 32'(word(recv)));
        recv++;
      end
      prev_stall = m_valid_o && !m_ready_i;
      prev_d     = m_data_o;
      @(negedge clk_i);
    end
    chk("t4_words_delivered", 32'(recv), 32'd1000);
    m_ready_i = 1'b1; clk_en_i = 1'b1;
    for (int i = 0; i < 4; i++) @(negedge clk_i);

    // Reset with two buffered words and one in flight
    push(8'h11); push(8'h22); push(8'h33); push(8'h44); push(8'h55);
    run_vec('{1'b1, 1'b0, 1'b1, 1'b0, 8'h00}, "t5_fill0");
    run_vec('{1'b1, 1'b0, 1'b1, 1'b0, 8'h00}, "t5_fill1");
    run_vec('{1'b1, 1'b0, 1'b1, 1'b1, 8'h11}, "t5_fill2");
    rst_i = 1'b0;
    #1;
    chk("t5_async_valid", 32'(m_valid_o), 32'd0);
    chk("t5_async_data", 32'(m_data_o), 32'd0);
    chk("t5_async_ren", 32'(fifo_r_en_o), 32'd0);
    tail = head;
    @(negedge clk_i);
    rst_i = 1'b1;
    for (int i = 0; i < 3; i++) run_vec('{1'b1, 1'b1, 1'b0, 1'b0, 8'h00}, "t5_nostale");
    push(8'h66);
    run_vec('{1'b1, 1'b1, 1'b1, 1'b0, 8'h00}, "t5_new0");
    run_vec('{1'b1, 1'b1, 1'b0, 1'b0, 8'h00}, "t5_new1");
    run_vec('{1'b1, 1'b1, 1'b0, 1'b1, 8'h66}, "t5_new2");
    run_vec('{1'b1, 1'b1, 1'b0, 1'b0, 8'h00}, "t5_new3");

`ifdef FIFO_RD_STREAM_STATS_EN
    // Ten transfers with four stalled cycles
    rst_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    chk("t6_xfer_reset", xfer_count_o, 32'd0);
    chk("t6_stall_reset", stall_count_o, 32'd0);
    for (int i = 0; i < 10; i++) push(8'(8'hA0 + i));
    clk_en_i = 1'b1; m_ready_i = 1'b0;
    for (int i = 0; i < 6; i++) @(negedge clk_i);
    m_ready_i = 1'b1;
    for (int i = 0; i < 20; i++) @(negedge clk_i);
    chk("t6_xfer_count", xfer_count_o, 32'd10);
    chk("t6_stall_count", stall_count_o, 32'd4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
